// File: rtl/imem_program_loader_if.sv
// Host-side program load channel: byte stream in, load status out.
// The master modport is the host, and the slave modport is the loader.
interface imem_program_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   load_count;
  logic [DATA_W-1:0] load_sum;

  modport master (
    output load_start, load_valid, load_data, load_last,
    input  load_ready, cpu_hold, load_done, load_error, load_count, load_sum
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last,
    output load_ready, cpu_hold, load_done, load_error, load_count, load_sum
  );
endinterface

// File: rtl/imem_program_loader.sv
// Writable instruction memory. A host streams a program in from address 0 while the CPU is held.
// The CPU is then released to fetch the new program through a zero-latency read port.
module imem_program_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned HOLD_EXTRA = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     Read_Address,
  output logic [DATA_W-1:0]     Instruction,
  imem_program_loader_if.slave  bus
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned HOLD_W = (HOLD_EXTRA < 2) ? 1 : $clog2(HOLD_EXTRA + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_sum;
  logic                r_done;
  logic                r_error;
  logic [HOLD_W-1:0]   r_hold;

  state_t              w_state_next;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [CNT_W-1:0]    w_count_next;
  logic [DATA_W-1:0]   w_sum_next;
  logic                w_done_next;
  logic                w_error_next;
  logic [HOLD_W-1:0]   w_hold_next;
  logic                w_xfer;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  // A start pulse always wins over a byte presented in the same cycle.
  assign w_xfer = (r_state == LOAD) && bus.load_valid && !bus.load_start;

  // State and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_sum   <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_count <= w_count_next;
      r_sum   <= w_sum_next;
      r_done  <= w_done_next;
      r_error <= w_error_next;
      r_hold  <= w_hold_next;
    end
  end

  // Next-state and next-status logic.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_count_next = r_count;
    w_sum_next   = r_sum;
    w_done_next  = r_done;
    w_error_next = r_error;
    w_hold_next  = r_hold;

    if (bus.load_start) begin
      w_state_next = LOAD;
      w_addr_next  = '0;
      w_count_next = '0;
      w_sum_next   = '0;
      w_done_next  = 1'b0;
      w_error_next = 1'b0;
      w_hold_next  = '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_xfer) begin
            w_addr_next  = r_addr + ADDR_W'(1);
            w_count_next = r_count + CNT_W'(1);
            w_sum_next   = r_sum + bus.load_data;
            if (bus.load_last) begin
              if (HOLD_EXTRA == 0) begin
                w_state_next = RUN;
                w_done_next  = 1'b1;
              end else begin
                w_state_next = RELEASE;
                w_hold_next  = HOLD_W'(HOLD_EXTRA);
              end
            end else if (r_addr == ADDR_W'(DEPTH - 1)) begin
              w_state_next = IDLE;
              w_error_next = 1'b1;
            end
          end
        end
        RELEASE: begin
          if (r_hold <= HOLD_W'(1)) begin
            w_state_next = RUN;
            w_done_next  = 1'b1;
            w_hold_next  = '0;
          end else begin
            w_hold_next  = r_hold - HOLD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Program storage. Reset does not clear it, so a reset does not wipe a loaded program.
  always_ff @(posedge clk) begin
    if (!reset && w_xfer) begin
      r_mem[r_addr] <= bus.load_data;
    end
  end

  // A partially loaded program reads back as NOP.
  assign Instruction = ((r_state == RUN) || (r_state == IDLE)) ? r_mem[Read_Address] : '0;

  assign bus.load_ready = (r_state == LOAD);
  assign bus.cpu_hold   = (r_state != RUN);
  assign bus.load_done  = r_done;
  assign bus.load_error = r_error;
  assign bus.load_count = r_count;
  assign bus.load_sum   = r_sum;

endmodule
